// File: rtl/localbus_arbiter.sv
// Two-master round-robin arbiter for the LocalBus slave side with bounded bursts
// and read-return steering through an RD_LAT-deep tag pipeline.
module localbus_arbiter #(
    parameter int XLEN      = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [2:0]      m0_we,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [2:0]      m1_we,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_qin,
    output logic [2:0]      bus_we,
    input  logic [XLEN-1:0] bus_qout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_MAX = 8'(MAX_BURST - 1);

    state_t            state;
    state_t            state_next;
    logic              last;
    logic [7:0]        count;
    logic [7:0]        count_next;
    logic              xfer;
    logic              owner;
    logic [2:0]        owner_we;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_id;
    logic              ret_valid;
    logic              ret_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state_next == OWN0 && state != OWN0) begin
                last <= 1'b0;
            end else if (state_next == OWN1 && state != OWN1) begin
                last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_next = last ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_next = OWN0;
                end else if (m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                m0_gnt = m0_req;
                if (!m0_req) begin
                    state_next = m1_req ? OWN1 : IDLE;
                end else if (m1_req && count == COUNT_MAX) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                m1_gnt = m1_req;
                if (!m1_req) begin
                    state_next = m0_req ? OWN0 : IDLE;
                end else if (m0_req && count == COUNT_MAX) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The count saturates so a lone owner never wraps into a spurious handoff.
    always_comb begin
        count_next = count;
        if (state_next != state) begin
            count_next = '0;
        end else if (xfer && count != COUNT_MAX) begin
            count_next = count + 8'd1;
        end
    end

    always_comb begin
        xfer     = m0_gnt | m1_gnt;
        owner    = (state == OWN1);
        owner_we = owner ? m1_we : m0_we;
        bus_we   = xfer ? owner_we : 3'b000;
        bus_addr = '0;
        bus_qin  = '0;
        if (state == OWN0) begin
            bus_addr = m0_addr;
            bus_qin  = m0_wdata;
        end else if (state == OWN1) begin
            bus_addr = m1_addr;
            bus_qin  = m1_wdata;
        end
    end

    // Tags travel alongside the slave's read latency so returns survive handoffs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            tag_valid[0] <= xfer && (owner_we == 3'b000);
            tag_id[0]    <= owner;
        end
    end

    always_comb begin
        ret_valid = tag_valid[RD_LAT-1];
        ret_id    = tag_id[RD_LAT-1];
        m0_rvalid = ret_valid && !ret_id;
        m1_rvalid = ret_valid && ret_id;
        m0_rdata  = m0_rvalid ? bus_qout : '0;
        m1_rdata  = m1_rvalid ? bus_qout : '0;
    end

endmodule

// File: tb/tb_localbus_arbiter.sv
// Directed bench for localbus_arbiter: instance a (RD_LAT=1, MAX_BURST=8) and
// instance b (RD_LAT=2, MAX_BURST=2) share inputs, each backed by a small RAM model.
module tb_localbus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [2:0]  m0_we;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [2:0]  m1_we;

    logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a;
    logic [31:0] m0_rdata_a, m1_rdata_a, bus_addr_a, bus_qin_a, bus_qout_a;
    logic [2:0]  bus_we_a;
    logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, bus_addr_b, bus_qin_b, bus_qout_b;
    logic [2:0]  bus_we_b;
    logic [31:0] q_b1;

    int checks_total;
    int checks_passed;

    localbus_arbiter #(.XLEN(32), .RD_LAT(1), .MAX_BURST(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
        .bus_addr(bus_addr_a), .bus_qin(bus_qin_a), .bus_we(bus_we_a),
        .bus_qout(bus_qout_a)
    );

    localbus_arbiter #(.XLEN(32), .RD_LAT(2), .MAX_BURST(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
        .bus_addr(bus_addr_b), .bus_qin(bus_qin_b), .bus_we(bus_we_b),
        .bus_qout(bus_qout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_val(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    // Synchronous-read RAM models matching each instance's read latency.
    always @(posedge clk) begin
        bus_qout_a <= ram_val(bus_addr_a);
        q_b1       <= ram_val(bus_addr_b);
        bus_qout_b <= q_b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [2:0] we0, input logic [31:0] a0,
                                 input logic r1, input logic [2:0] we1, input logic [31:0] a1);
        m0_req   = r0;
        m0_we    = we0;
        m0_addr  = a0;
        m0_wdata = a0 ^ 32'h1111_1111;
        m1_req   = r1;
        m1_we    = we1;
        m1_addr  = a1;
        m1_wdata = a1 ^ 32'h2222_2222;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge, at the start of cycle 0.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 32'h0, 1'b0, 3'b000, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;

        // Outputs held at zero under reset even with both masters requesting.
        applyStimulus(1'b1, 3'b001, 32'h0000_0ABC, 1'b1, 3'b000, 32'h0000_0DEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst m0_gnt", 32'(m0_gnt_a), 32'd0);
        checkOutput("rst m1_gnt", 32'(m1_gnt_a), 32'd0);
        checkOutput("rst bus_addr", bus_addr_a, 32'd0);
        checkOutput("rst bus_qin", bus_qin_a, 32'd0);
        checkOutput("rst bus_we", 32'(bus_we_a), 32'd0);
        checkOutput("rst m0_rvalid", 32'(m0_rvalid_a), 32'd0);
        checkOutput("rst m1_rdata", m1_rdata_a, 32'd0);

        // Single master 0 read.
        doReset();
        applyStimulus(1'b1, 3'b000, 32'h0000_0010, 1'b0, 3'b000, 32'h0);
        @(negedge clk);
        checkOutput("rd0 c0 m0_gnt", 32'(m0_gnt_a), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd0 c1 m0_gnt", 32'(m0_gnt_a), 32'd1);
        checkOutput("rd0 c1 bus_addr", bus_addr_a, 32'h0000_0010);
        checkOutput("rd0 c1 bus_we", 32'(bus_we_a), 32'd0);
        nextCycle();
        m0_req = 1'b0;
        @(negedge clk);
        checkOutput("rd0 c2 m0_rvalid", 32'(m0_rvalid_a), 32'd1);
        checkOutput("rd0 c2 m0_rdata", m0_rdata_a, 32'h5A5A_0010);
        checkOutput("rd0 c2 m1_rvalid", 32'(m1_rvalid_a), 32'd0);
        checkOutput("rd0 c2 m0_gnt", 32'(m0_gnt_a), 32'd0);
        checkOutput("rd0 c2 b m0_rvalid", 32'(m0_rvalid_b), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd0 c3 m0_rvalid", 32'(m0_rvalid_a), 32'd0);
        checkOutput("rd0 c3 b m0_rvalid", 32'(m0_rvalid_b), 32'd1);
        checkOutput("rd0 c3 b m0_rdata", m0_rdata_b, 32'h5A5A_0010);

        // Tie after reset: master 0 owns cycles 1-8, master 1 9-16, master 0 again from 17.
        doReset();
        applyStimulus(1'b1, 3'b001, 32'h0000_0100, 1'b1, 3'b011, 32'h0000_0200);
        for (int c = 0; c <= 18; c++) begin
            logic e0, e1;
            e0 = (c >= 1 && c <= 8) || (c >= 17);
            e1 = (c >= 9 && c <= 16);
            @(negedge clk);
            checkOutput($sformatf("tie c%0d m0_gnt", c), 32'(m0_gnt_a), 32'(e0));
            checkOutput($sformatf("tie c%0d m1_gnt", c), 32'(m1_gnt_a), 32'(e1));
            checkOutput($sformatf("tie c%0d bus_we", c), 32'(bus_we_a),
                        e0 ? 32'd1 : (e1 ? 32'd3 : 32'd0));
            nextCycle();
        end

        // Single-cycle handoff, then write qualification around a dropped m1_req.
        doReset();
        applyStimulus(1'b1, 3'b001, 32'h0000_0300, 1'b0, 3'b010, 32'h0008_0040);
        for (int c = 0; c <= 8; c++) begin
            if (c == 2) m1_req = 1'b1;
            if (c == 3) m0_req = 1'b0;
            if (c == 5) m1_req = 1'b0;
            if (c == 6) m1_req = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                checkOutput("ho c3 m1_gnt", 32'(m1_gnt_a), 32'd0);
                checkOutput("ho c3 bus_we", 32'(bus_we_a), 32'd0);
            end
            if (c == 4) begin
                checkOutput("ho c4 m1_gnt", 32'(m1_gnt_a), 32'd1);
                checkOutput("ho c4 m0_gnt", 32'(m0_gnt_a), 32'd0);
                checkOutput("ho c4 bus_we", 32'(bus_we_a), 32'd2);
                checkOutput("ho c4 bus_addr", bus_addr_a, 32'h0008_0040);
                checkOutput("ho c4 bus_qin", bus_qin_a, 32'h0008_0040 ^ 32'h2222_2222);
            end
            if (c == 5) begin
                checkOutput("wq c5 m1_gnt", 32'(m1_gnt_a), 32'd0);
                checkOutput("wq c5 bus_we", 32'(bus_we_a), 32'd0);
            end
            if (c == 6) begin
                checkOutput("wq c6 m1_gnt", 32'(m1_gnt_a), 32'd0);
                checkOutput("wq c6 bus_addr", bus_addr_a, 32'd0);
            end
            if (c == 7) begin
                checkOutput("wq c7 m1_gnt", 32'(m1_gnt_a), 32'd1);
                checkOutput("wq c7 bus_we", 32'(bus_we_a), 32'd2);
            end
            if (c >= 4) begin
                checkOutput($sformatf("wq c%0d m1_rvalid", c), 32'(m1_rvalid_a), 32'd0);
            end
            nextCycle();
        end

        // Reads across a burst-limit handoff on instance b (RD_LAT=2, MAX_BURST=2).
        doReset();
        applyStimulus(1'b0, 3'b001, 32'h0000_0020, 1'b0, 3'b000, 32'h0000_0030);
        for (int c = 0; c <= 10; c++) begin
            logic e0v, e1v;
            if (c == 3) begin
                m0_req = 1'b1;
                m1_req = 1'b1;
            end
            if (c == 5) m0_we  = 3'b000;
            if (c == 6) m0_req = 1'b0;
            if (c == 7) m1_req = 1'b0;
            e0v = (c == 7);
            e1v = (c == 8);
            @(negedge clk);
            if (c == 5) checkOutput("xr c5 b m0_gnt", 32'(m0_gnt_b), 32'd1);
            if (c == 6) checkOutput("xr c6 b m1_gnt", 32'(m1_gnt_b), 32'd1);
            checkOutput($sformatf("xr c%0d b m0_rvalid", c), 32'(m0_rvalid_b), 32'(e0v));
            checkOutput($sformatf("xr c%0d b m1_rvalid", c), 32'(m1_rvalid_b), 32'(e1v));
            if (c == 7) begin
                checkOutput("xr c7 b m0_rdata", m0_rdata_b, 32'h5A5A_0020);
                checkOutput("xr c7 b m1_rdata", m1_rdata_b, 32'd0);
            end
            if (c == 8) begin
                checkOutput("xr c8 b m1_rdata", m1_rdata_b, 32'h5A5A_0030);
                checkOutput("xr c8 b m0_rdata", m0_rdata_b, 32'd0);
            end
            nextCycle();
        end

        // Reset asserted between a read grant and its return.
        doReset();
        applyStimulus(1'b1, 3'b000, 32'h0000_0040, 1'b0, 3'b000, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("rr c1 m0_gnt", 32'(m0_gnt_a), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rr async m0_gnt", 32'(m0_gnt_a), 32'd0);
        checkOutput("rr async bus_addr", bus_addr_a, 32'd0);
        nextCycle();
        m1_req = 1'b1;
        @(negedge clk);
        checkOutput("rr c2 a m0_rvalid", 32'(m0_rvalid_a), 32'd0);
        checkOutput("rr c2 a m0_rdata", m0_rdata_a, 32'd0);
        checkOutput("rr c2 b m0_rvalid", 32'(m0_rvalid_b), 32'd0);
        checkOutput("rr c2 bus_we", 32'(bus_we_a), 32'd0);
        checkOutput("rr c2 m1_gnt", 32'(m1_gnt_a), 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rr c3 m0_gnt", 32'(m0_gnt_a), 32'd0);
        checkOutput("rr c3 b m0_rvalid", 32'(m0_rvalid_b), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rr c4 m0_gnt", 32'(m0_gnt_a), 32'd1);
        checkOutput("rr c4 m1_gnt", 32'(m1_gnt_a), 32'd0);
        checkOutput("rr c4 a m0_rvalid", 32'(m0_rvalid_a), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/localbus_arbiter.md
Name: localbus_arbiter

Overview:
- Two-master arbiter in front of the LocalBus slave side (data RAM, GPIO, VGA).
- Master 0 is the CPU load/store port; master 1 is a DMA/blit requester, for example a VRAM fill engine.
- Shares one addr/qin/we/qout path using round-robin ownership with a bounded burst length.
- Tags reads so that each read-data return is steered to the master that issued it, after a fixed read latency.

Parameters:
- XLEN, 32, bus data and address width.
- RD_LAT, 1, cycles from read transfer to valid bus_qout (Block RAM synchronous read); legal range 1–4.
- MAX_BURST, 8, maximum consecutive transfers by one owner while the other master is requesting; legal range 1–255.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 access request
- m0_addr  in  XLEN  master 0 address
- m0_wdata  in  XLEN  master 0 write data
- m0_we  in  3  master 0 write enable, LocalBus encoding; 000 = read
- m0_gnt  out  1  master 0 transfer accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  XLEN  master 0 read data
- m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1
- bus_addr  out  XLEN  LocalBus addr
- bus_qin  out  XLEN  LocalBus write data
- bus_we  out  3  LocalBus write enable
- bus_qout  in  XLEN  LocalBus read data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: FSM = IDLE, last = 1 (so master 0 wins the first tie), burst count = 0, read-tag pipeline cleared.
- Output values while rst is high: all gnt = 0, all rvalid = 0, all rdata = 0, bus_addr = 0, bus_qin = 0, bus_we = 000.
- FSM states are IDLE, OWN0 and OWN1. All transitions occur on the clk rising edge.
- From IDLE:
  - m0_req and m1_req both high: go to OWNk where k != last.
  - Only one req high: go to that master's OWN state.
  - Neither high: stay in IDLE.
- Grant timing: no grant is issued in IDLE. A request that arrives while the FSM is idle sees gnt in the cycle after req is first sampled, so latency is 1 cycle.
- In OWNx: mx_gnt = mx_req, combinational from the state. A transfer occurs on every cycle where gnt = 1. The other master's gnt is 0.
- Bus muxing: bus_addr and bus_qin come from the owner. bus_we = owner_we when a transfer occurs, otherwise 000. In IDLE, bus_addr = 0 and bus_qin = 0.
- Burst count: increments on each transfer and clears when ownership changes or the FSM enters IDLE.
- Leaving OWNx:
  - If mx_req = 0, go to OWNy when my_req = 1, otherwise to IDLE. The handoff takes no idle gap cycle.
  - If a transfer occurs with count = MAX_BURST-1 and my_req = 1, go to OWNy even though mx_req is still high.
  - If my_req = 0, the owner keeps the bus indefinitely; the count saturates at MAX_BURST-1.
- last updates to x on every entry into OWNx.
- Read tagging: a transfer with we = 000 pushes {valid, id} into an RD_LAT-deep shift register. Writes push invalid.
- Read return: at the pipeline output, the rvalid of the master matching id is 1 for exactly one cycle, and that master's rdata = bus_qout. The other master's rdata = 0.
- Read return is independent of current ownership: a read issued just before a handoff still returns to its issuer.
- Write acknowledgement: none. A write is complete when it is granted.
- Reset during operation: an asynchronous return to the reset state. In-flight read tags are discarded and no rvalid is issued for them.
- Requests must hold addr, wdata and we stable until granted. A master may drop req before it is granted with no side effects.

Test Plan:
- Single master 0 read: m0_req held from cycle 0 with addr = 0x0000_0010 and we = 000 → m0_gnt = 1 at cycle 1. With RD_LAT = 1, m0_rvalid = 1 at cycle 2 with m0_rdata = RAM[0x10]; m1_rvalid stays 0.
- Tie after reset: both masters request at cycle 0 → OWN0 at cycle 1. Master 0 gets 8 grants (cycles 1–8), master 1 gets its first gnt at cycle 9 with no idle gap, then master 0 regains the bus after 8 more transfers (cycles 9–16).
- Single-cycle handoff: master 0 drops req in cycle 3 while m1_req = 1 → m1_gnt = 1 at cycle 4 and bus_we reflects m1_we at cycle 4.
- Reads across a handoff: master 0 read at cycle 5, master 1 read at cycle 6 (RD_LAT = 2) → m0_rvalid at cycle 7 and m1_rvalid at cycle 8, each carrying the correct bus_qout. Exactly two rvalid pulses total.
- Write qualification: master 1 writes we = 010 to a VGA address with m1_req low for one cycle mid-burst → bus_we = 000 in that cycle, no rvalid, and bus_we = 010 only on granted cycles.
- Reset during a read: assert rst between the master 0 read grant and its return → m0_rvalid never pulses, and all outputs read 0 during rst. After rst deasserts, a tie grants master 0 first.
